// File: rtl/nrf_pkg.sv
// ---------------------------------------------------------------------------
// nrf_pkg
// Shared definitions for the nRF24 link sequencer: FSM state encoding,
// SPI command opcodes, the radio configuration byte table and the decode
// of per-state status flags.
// No ports (package).
// ---------------------------------------------------------------------------
package nrf_pkg;

   typedef enum logic [3:0] {
      ST_IDLE        = 4'd0,
      ST_CFG_TX      = 4'd1,
      ST_WAIT_CFG_TX = 4'd2,
      ST_CFG_RX      = 4'd3,
      ST_WAIT_CFG_RX = 4'd4,
      ST_READY       = 4'd5,
      ST_SEND_CMD    = 4'd6,
      ST_WAIT_CMD    = 4'd7,
      ST_SEND_PL     = 4'd8,
      ST_WAIT_PL     = 4'd9,
      ST_RECV        = 4'd10,
      ST_WAIT_RECV   = 4'd11,
      ST_ERROR       = 4'd12
   } state_t;

   localparam logic [7:0] W_REGISTER   = 8'h20;
   localparam logic [7:0] W_TX_PAYLOAD = 8'hA0;
   localparam logic [7:0] R_RX_PAYLOAD = 8'h61;

   localparam int CFG_MAX = 16;

   // Command/data pairs: W_REGISTER|addr followed by the register value.
   localparam logic [7:0] CFG_TABLE [0:CFG_MAX-1] = '{
      W_REGISTER | 8'h00, 8'h0E,   // CONFIG: power up, CRC enabled
      W_REGISTER | 8'h01, 8'h00,   // EN_AA: auto-ack off
      W_REGISTER | 8'h03, 8'h03,   // SETUP_AW: 5-byte address
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   typedef struct packed {
      logic busy;
      logic cfg_done;
      logic error;
      logic pl_ready;
   } flags_t;

   // Status flags that must be visible while the FSM sits in state s.
   function automatic flags_t state_flags(input state_t s);
      flags_t f;
      f = 4'b0000;
      case (s)
         ST_IDLE:  f = 4'b0000;
         ST_READY: begin f.cfg_done = 1'b1; f.pl_ready = 1'b1; end
         ST_ERROR: f.error = 1'b1;
         default:  f.busy = 1'b1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/nrf_cfg_rom.sv
// ---------------------------------------------------------------------------
// nrf_cfg_rom
// Combinational lookup of configuration byte idx from the package table.
// Entries at or beyond CFG_LEN read as 0x00.
// Ports:
//   idx      in  4  byte index
//   cfg_byte out 8  configuration byte at idx
// ---------------------------------------------------------------------------
module nrf_cfg_rom
   import nrf_pkg::*;
#(
   parameter int CFG_LEN = 6
) (
   input  logic [3:0] idx,
   output logic [7:0] cfg_byte
);

   localparam logic [4:0] LEN_W = 5'(CFG_LEN);

   // Table lookup bounded by the configured length.
   always_comb begin
      if ({1'b0, idx} < LEN_W) begin
         cfg_byte = CFG_TABLE[idx];
      end else begin
         cfg_byte = 8'h00;
      end
   end

endmodule

// File: rtl/nrf_link_sequencer.sv
// ---------------------------------------------------------------------------
// nrf_link_sequencer
// Configures a TX and an RX nRF24 radio through a shared SPI controller,
// then repeatedly sends one payload byte and reads one byte back.
// Ports:
//   clk_10, rst                  10 MHz clock, async active-high reset
//   go                           start (re)configuration from IDLE/ERROR
//   pl_data, pl_valid, pl_ready  payload byte handshake (accepted in READY)
//   spi_data_in                  byte for the SPI controller, held until done
//   spi_start_tx, spi_start_rx   one-cycle start strobes
//   spi_done_tx, spi_done_rx     completion pulses
//   spi_data_out                 byte read back, valid with spi_done_rx
//   rx_data, rx_valid            last received byte and its update pulse
//   busy, cfg_done, error        status
// ---------------------------------------------------------------------------
module nrf_link_sequencer
   import nrf_pkg::*;
#(
   parameter int CFG_LEN = 6,
   parameter int TIMEOUT = 1023
) (
   input  logic       clk_10,
   input  logic       rst,
   input  logic       go,
   input  logic [7:0] pl_data,
   input  logic       pl_valid,
   output logic       pl_ready,
   output logic [7:0] spi_data_in,
   output logic       spi_start_tx,
   output logic       spi_start_rx,
   input  logic       spi_done_tx,
   input  logic       spi_done_rx,
   input  logic [7:0] spi_data_out,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       cfg_done,
   output logic       error
);

   localparam logic [3:0] LAST_IDX = 4'(CFG_LEN - 1);
   localparam logic [9:0] TMO      = 10'(TIMEOUT);

   state_t      state_r;
   flags_t      flags_r;
   logic [3:0]  idx_r;
   logic [9:0]  wait_cnt_r;
   logic [7:0]  payload_r;
   logic [7:0]  spi_data_in_r;
   logic        spi_start_tx_r;
   logic        spi_start_rx_r;
   logic [7:0]  rx_data_r;
   logic        rx_valid_r;
   logic [7:0]  cfg_byte_s;
   logic        done_ok_s;
   logic        timeout_s;

   nrf_cfg_rom #(.CFG_LEN(CFG_LEN)) u_cfg_rom (
      .idx      (idx_r),
      .cfg_byte (cfg_byte_s)
   );

   // Accept only the done of the radio being waited on, and never in the
   // strobe cycle itself (the controller cannot have finished yet).
   always_comb begin
      case (state_r)
         ST_WAIT_CFG_TX, ST_WAIT_CMD, ST_WAIT_PL: done_ok_s = spi_done_tx & ~spi_start_tx_r;
         ST_WAIT_CFG_RX, ST_WAIT_RECV:            done_ok_s = spi_done_rx & ~spi_start_rx_r;
         default:                                 done_ok_s = 1'b0;
      endcase
   end

   assign timeout_s = (wait_cnt_r == TMO);

   // Sequencer FSM; all outputs are registered here.
   always_ff @(posedge clk_10 or posedge rst) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         flags_r        <= 4'b0000;
         idx_r          <= 4'd0;
         wait_cnt_r     <= 10'd0;
         payload_r      <= 8'h00;
         spi_data_in_r  <= 8'h00;
         spi_start_tx_r <= 1'b0;
         spi_start_rx_r <= 1'b0;
         rx_data_r      <= 8'h00;
         rx_valid_r     <= 1'b0;
      end else begin
         spi_start_tx_r <= 1'b0;
         spi_start_rx_r <= 1'b0;
         rx_valid_r     <= 1'b0;
         case (state_r)
            ST_IDLE, ST_ERROR: begin
               if (go) begin
                  idx_r   <= 4'd0;
                  state_r <= ST_CFG_TX;
                  flags_r <= state_flags(ST_CFG_TX);
               end
            end
            ST_CFG_TX: begin
               spi_data_in_r  <= cfg_byte_s;
               spi_start_tx_r <= 1'b1;
               wait_cnt_r     <= 10'd0;
               state_r        <= ST_WAIT_CFG_TX;
            end
            ST_CFG_RX: begin
               spi_data_in_r  <= cfg_byte_s;
               spi_start_rx_r <= 1'b1;
               wait_cnt_r     <= 10'd0;
               state_r        <= ST_WAIT_CFG_RX;
            end
            ST_READY: begin
               if (pl_valid && flags_r.pl_ready) begin
                  payload_r <= pl_data;
                  state_r   <= ST_SEND_CMD;
                  flags_r   <= state_flags(ST_SEND_CMD);
               end
            end
            ST_SEND_CMD: begin
               spi_data_in_r  <= W_TX_PAYLOAD;
               spi_start_tx_r <= 1'b1;
               wait_cnt_r     <= 10'd0;
               state_r        <= ST_WAIT_CMD;
            end
            ST_SEND_PL: begin
               spi_data_in_r  <= payload_r;
               spi_start_tx_r <= 1'b1;
               wait_cnt_r     <= 10'd0;
               state_r        <= ST_WAIT_PL;
            end
            ST_RECV: begin
               spi_data_in_r  <= R_RX_PAYLOAD;
               spi_start_rx_r <= 1'b1;
               wait_cnt_r     <= 10'd0;
               state_r        <= ST_WAIT_RECV;
            end
            ST_WAIT_CFG_TX, ST_WAIT_CFG_RX, ST_WAIT_CMD, ST_WAIT_PL, ST_WAIT_RECV: begin
               if (done_ok_s) begin
                  case (state_r)
                     ST_WAIT_CFG_TX: begin
                        if (idx_r == LAST_IDX) begin
                           idx_r   <= 4'd0;
                           state_r <= ST_CFG_RX;
                        end else begin
                           idx_r   <= idx_r + 4'd1;
                           state_r <= ST_CFG_TX;
                        end
                     end
                     ST_WAIT_CFG_RX: begin
                        if (idx_r == LAST_IDX) begin
                           idx_r   <= 4'd0;
                           state_r <= ST_READY;
                           flags_r <= state_flags(ST_READY);
                        end else begin
                           idx_r   <= idx_r + 4'd1;
                           state_r <= ST_CFG_RX;
                        end
                     end
                     ST_WAIT_CMD: state_r <= ST_SEND_PL;
                     ST_WAIT_PL:  state_r <= ST_RECV;
                     default: begin
                        rx_data_r  <= spi_data_out;
                        rx_valid_r <= 1'b1;
                        state_r    <= ST_READY;
                        flags_r    <= state_flags(ST_READY);
                     end
                  endcase
               end else if (timeout_s) begin
                  state_r <= ST_ERROR;
                  flags_r <= state_flags(ST_ERROR);
               end else begin
                  wait_cnt_r <= wait_cnt_r + 10'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               flags_r <= state_flags(ST_IDLE);
            end
         endcase
      end
   end

   assign pl_ready     = flags_r.pl_ready;
   assign busy         = flags_r.busy;
   assign cfg_done     = flags_r.cfg_done;
   assign error        = flags_r.error;
   assign spi_data_in  = spi_data_in_r;
   assign spi_start_tx = spi_start_tx_r;
   assign spi_start_rx = spi_start_rx_r;
   assign rx_data      = rx_data_r;
   assign rx_valid     = rx_valid_r;

endmodule

// File: tb/tb_nrf_link_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nrf_link_sequencer
// Directed bench with a scoreboard of expected SPI bytes and received data,
// plus a simple SPI controller model that answers each strobe with a done
// pulse three cycles later.
// ---------------------------------------------------------------------------
module tb_nrf_link_sequencer;

   localparam int CFG_LEN = 6;
   localparam int TIMEOUT = 1023;

   logic       clk_10 = 1'b0;
   logic       rst;
   logic       go;
   logic [7:0] pl_data;
   logic       pl_valid;
   logic       pl_ready;
   logic [7:0] spi_data_in;
   logic       spi_start_tx;
   logic       spi_start_rx;
   logic       spi_done_tx;
   logic       spi_done_rx;
   logic [7:0] spi_data_out;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       cfg_done;
   logic       error;

   logic       resp_tx = 1'b0, resp_rx = 1'b0;
   logic       inj_tx, inj_rx;
   logic       resp_en;
   logic [7:0] rx_reply;
   int         tx_pend = 0, rx_pend = 0;

   int         errors = 0;
   int         checks = 0;
   int         n_tx = 0, n_rx = 0, n_rxv = 0;

   logic [7:0] exp_tx_q [$];
   logic [7:0] exp_rx_q [$];
   logic [7:0] exp_rxd_q [$];

   logic [7:0] cfg_ref [0:CFG_LEN-1] = '{8'h20, 8'h0E, 8'h21, 8'h00, 8'h23, 8'h03};

   assign spi_done_tx  = resp_tx | inj_tx;
   assign spi_done_rx  = resp_rx | inj_rx;
   assign spi_data_out = rx_reply;

   nrf_link_sequencer #(.CFG_LEN(CFG_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk_10       (clk_10),
      .rst          (rst),
      .go           (go),
      .pl_data      (pl_data),
      .pl_valid     (pl_valid),
      .pl_ready     (pl_ready),
      .spi_data_in  (spi_data_in),
      .spi_start_tx (spi_start_tx),
      .spi_start_rx (spi_start_rx),
      .spi_done_tx  (spi_done_tx),
      .spi_done_rx  (spi_done_rx),
      .spi_data_out (spi_data_out),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .busy         (busy),
      .cfg_done     (cfg_done),
      .error        (error)
   );

   always #5 clk_10 = ~clk_10;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_10);
      #1;
   endtask

   // SPI controller model and scoreboard monitor, sampled on the falling edge.
   always @(negedge clk_10) begin
      resp_tx = 1'b0;
      resp_rx = 1'b0;
      if (tx_pend > 0) begin
         tx_pend--;
         if (tx_pend == 0) resp_tx = 1'b1;
      end
      if (rx_pend > 0) begin
         rx_pend--;
         if (rx_pend == 0) resp_rx = 1'b1;
      end
      if (spi_start_tx || spi_start_rx)
         chk("strobe_exclusive", {31'd0, spi_start_tx & spi_start_rx}, 32'd0);
      if (spi_start_tx) begin
         n_tx++;
         chk("tx_strobe_expected", {31'd0, exp_tx_q.size() != 0}, 32'd1);
         if (exp_tx_q.size() != 0) chk("tx_byte", {24'd0, spi_data_in}, {24'd0, exp_tx_q.pop_front()});
         if (resp_en) tx_pend = 3;
      end
      if (spi_start_rx) begin
         n_rx++;
         chk("rx_strobe_expected", {31'd0, exp_rx_q.size() != 0}, 32'd1);
         if (exp_rx_q.size() != 0) chk("rx_cmd_byte", {24'd0, spi_data_in}, {24'd0, exp_rx_q.pop_front()});
         if (resp_en) rx_pend = 3;
      end
      if (rx_valid) begin
         n_rxv++;
         chk("rx_valid_expected", {31'd0, exp_rxd_q.size() != 0}, 32'd1);
         if (exp_rxd_q.size() != 0) chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rxd_q.pop_front()});
      end
   end

   // Absolute time limit so the run always ends.
   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      int t0;
      int t1;
      int rxv0;
      int k;
      logic ack_seen;

      rst = 1'b1; go = 1'b0; pl_data = 8'h00; pl_valid = 1'b0;
      inj_tx = 1'b0; inj_rx = 1'b0; resp_en = 1'b1; rx_reply = 8'h00;
      repeat (3) step();
      chk("reset_outputs", {9'd0, pl_ready, busy, cfg_done, error, spi_start_tx, spi_start_rx,
                            rx_valid, spi_data_in, rx_data}, 32'd0);
      rst = 1'b0;
      step();
      chk("idle_status", {28'd0, busy, cfg_done, error, pl_ready}, 32'd0);

      // Full configuration; go during CFG_RX and a held pl_valid must be ignored.
      for (int i = 0; i < CFG_LEN; i++) begin
         exp_tx_q.push_back(cfg_ref[i]);
         exp_rx_q.push_back(cfg_ref[i]);
      end
      pl_data = 8'h77; pl_valid = 1'b1; ack_seen = 1'b0;
      go = 1'b1; step(); go = 1'b0;
      chk("busy_after_go", {31'd0, busy}, 32'd1);
      guard = 0;
      while (n_rx < 1 && guard < 300) begin
         if (pl_ready) ack_seen = 1'b1;
         step(); guard++;
      end
      chk("first_rx_strobe_seen", {31'd0, n_rx >= 1}, 32'd1);
      // Strobe cycle + 3 to done + 1 lands in CFG_RX of the second byte.
      repeat (4) begin
         if (pl_ready) ack_seen = 1'b1;
         step();
      end
      go = 1'b1; step(); go = 1'b0;
      guard = 0;
      while (n_rx < CFG_LEN && guard < 300) begin
         if (pl_ready) ack_seen = 1'b1;
         step(); guard++;
      end
      pl_valid = 1'b0;
      chk("no_ack_during_cfg", {31'd0, ack_seen}, 32'd0);
      guard = 0;
      while (!cfg_done && guard < 50) begin step(); guard++; end
      chk("cfg_done", {31'd0, cfg_done}, 32'd1);
      chk("ready_pl_ready", {31'd0, pl_ready}, 32'd1);
      chk("ready_busy", {31'd0, busy}, 32'd0);
      chk("cfg_tx_count", n_tx, CFG_LEN);
      chk("cfg_rx_count", n_rx, CFG_LEN);
      chk("cfg_queues_empty", exp_tx_q.size() + exp_rx_q.size(), 0);

      // One payload round trip.
      exp_tx_q.push_back(8'hA0); exp_tx_q.push_back(8'h5A);
      exp_rx_q.push_back(8'h61); exp_rxd_q.push_back(8'hC3);
      rx_reply = 8'hC3; rxv0 = n_rxv;
      pl_data = 8'h5A; pl_valid = 1'b1; step(); pl_valid = 1'b0;
      chk("pl_ready_drops", {31'd0, pl_ready}, 32'd0);
      chk("payload_busy", {31'd0, busy}, 32'd1);
      guard = 0;
      while (!cfg_done && guard < 100) begin step(); guard++; end
      chk("payload_back_to_ready", {31'd0, cfg_done}, 32'd1);
      chk("rx_data_value", {24'd0, rx_data}, 32'h0000_00C3);
      chk("rx_valid_pulses", n_rxv - rxv0, 1);
      step();
      chk("rx_valid_single", {31'd0, rx_valid}, 32'd0);
      chk("payload_queues_empty", exp_tx_q.size() + exp_rx_q.size() + exp_rxd_q.size(), 0);

      // Reset in WAIT_PL aborts the transfer.
      exp_tx_q.push_back(8'hA0); exp_tx_q.push_back(8'h3C);
      t0 = n_tx;
      pl_data = 8'h3C; pl_valid = 1'b1; step(); pl_valid = 1'b0;
      guard = 0;
      while (n_tx < t0 + 2 && guard < 50) begin step(); guard++; end
      chk("reached_wait_pl", n_tx, t0 + 2);
      rst = 1'b1; #1;
      chk("async_reset_outputs", {9'd0, pl_ready, busy, cfg_done, error, spi_start_tx, spi_start_rx,
                                  rx_valid, spi_data_in, rx_data}, 32'd0);
      step(); step();
      rst = 1'b0;
      t1 = n_tx + n_rx; ack_seen = 1'b0; pl_valid = 1'b1;
      repeat (10) begin
         step();
         if (pl_ready) ack_seen = 1'b1;
      end
      pl_valid = 1'b0;
      chk("no_ack_after_reset", {31'd0, ack_seen}, 32'd0);
      chk("no_strobe_after_reset", n_tx + n_rx, t1);
      chk("idle_after_reset", {28'd0, busy, cfg_done, error, pl_ready}, 32'd0);

      // Withheld done: error after the timeout.
      resp_en = 1'b0;
      exp_tx_q.push_back(cfg_ref[0]);
      t0 = n_tx;
      go = 1'b1; step(); go = 1'b0;
      guard = 0;
      while (n_tx < t0 + 1 && guard < 20) begin step(); guard++; end
      chk("timeout_first_strobe", n_tx, t0 + 1);
      k = 0;
      while (!error && k < 1100) begin step(); k++; end
      // Counter is 0 in the strobe cycle and reaches TIMEOUT TIMEOUT cycles
      // later; ERROR is visible one cycle after that.
      chk("timeout_cycles", k, TIMEOUT + 1);
      chk("error_flag", {31'd0, error}, 32'd1);
      chk("error_not_busy", {31'd0, busy}, 32'd0);
      repeat (5) step();
      chk("error_sticky", {31'd0, error}, 32'd1);

      // Restart from ERROR; ignored dones must not advance the sequence.
      exp_tx_q.push_back(cfg_ref[0]);
      t0 = n_tx;
      go = 1'b1; step(); go = 1'b0;
      chk("restart_error_cleared", {31'd0, error}, 32'd0);
      chk("restart_busy", {31'd0, busy}, 32'd1);
      step();
      chk("restart_strobe", n_tx, t0 + 1);
      inj_tx = 1'b1; step(); inj_tx = 1'b0;
      inj_rx = 1'b1; step(); inj_rx = 1'b0;
      repeat (4) step();
      chk("ignored_done_no_advance", n_tx, t0 + 1);
      chk("ignored_done_busy", {30'd0, busy, error}, 32'd2);
      resp_en = 1'b1;
      for (int i = 1; i < CFG_LEN; i++) exp_tx_q.push_back(cfg_ref[i]);
      for (int i = 0; i < CFG_LEN; i++) exp_rx_q.push_back(cfg_ref[i]);
      inj_tx = 1'b1; step(); inj_tx = 1'b0;
      guard = 0;
      while (!cfg_done && guard < 400) begin step(); guard++; end
      chk("restart_cfg_done", {31'd0, cfg_done}, 32'd1);
      chk("restart_queues_empty", exp_tx_q.size() + exp_rx_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nrf_link_sequencer.md
NRF_LINK_SEQUENCER -- requirements
Module: nrf_link_sequencer

Interface
REQ-001 Parameter CFG_LEN, default 6, number of configuration bytes sent to each radio (range 1..16).
REQ-002 Parameter TIMEOUT, default 1023, maximum clk_10 cycles spent waiting for any done; 10-bit counter.
REQ-003 clk_10  in  1  single 10 MHz clock; all logic on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 go  in  1  one-cycle pulse; starts the configuration of both radios.
REQ-006 pl_data  in  8  payload byte to transmit.
REQ-007 pl_valid  in  1  pl_data valid; transfer occurs when pl_valid and pl_ready are both 1.
REQ-008 pl_ready  out  1  high only in state READY.
REQ-009 spi_data_in  out  8  byte presented to spi_controller data_in; held stable from strobe until done.
REQ-010 spi_start_tx / spi_start_rx  out  1 each  one-cycle start strobes to the SPI controller.
REQ-011 spi_done_tx / spi_done_rx  in  1 each  completion pulses from the SPI controller.
REQ-012 spi_data_out  in  8  byte received from the RX radio, valid in the spi_done_rx cycle.
REQ-013 rx_data  out  8  last received payload byte; rx_valid  out  1  one-cycle pulse when rx_data updates.
REQ-014 busy  out  1  high in every state except IDLE, READY and ERROR; cfg_done  out  1  high in READY; error  out  1  high in ERROR.

Function
REQ-015 States: IDLE, CFG_TX, WAIT_CFG_TX, CFG_RX, WAIT_CFG_RX, READY, SEND_CMD, WAIT_CMD, SEND_PL, WAIT_PL, RECV, WAIT_RECV, ERROR.
REQ-016 IDLE -> CFG_TX on go; byte index idx cleared to 0.
REQ-017 CFG_TX: drive spi_data_in = cfg byte idx and pulse spi_start_tx for exactly one cycle; next state WAIT_CFG_TX.
REQ-018 WAIT_CFG_TX: on spi_done_tx, if idx = CFG_LEN-1 clear idx and go to CFG_RX, else increment idx and return to CFG_TX.
REQ-019 CFG_RX/WAIT_CFG_RX: identical sequence using spi_start_rx/spi_done_rx; after the last byte go to READY.
REQ-020 READY: on a pl_valid/pl_ready handshake, capture pl_data into an internal register and go to SEND_CMD.
REQ-021 SEND_CMD pulses spi_start_tx with W_TX_PAYLOAD (0xA0); WAIT_CMD -> SEND_PL on spi_done_tx.
REQ-022 SEND_PL pulses spi_start_tx with the captured payload; WAIT_PL -> RECV on spi_done_tx.
REQ-023 RECV pulses spi_start_rx with R_RX_PAYLOAD (0x61); WAIT_RECV on spi_done_rx loads rx_data from spi_data_out, pulses rx_valid the next cycle, and returns to READY.
REQ-024 A done pulse is sampled only in WAIT_* states; a done on the same cycle as its start strobe or in any other state is ignored.
REQ-025 Done pulses for the radio not being waited on are ignored.
REQ-026 The wait counter clears on every start strobe and increments in WAIT_* states; reaching TIMEOUT without the expected done moves to ERROR.
REQ-027 ERROR is sticky; only go (restarts at CFG_TX, error cleared) or rst leaves it.
REQ-028 go outside IDLE and ERROR is ignored; pl_valid outside READY is not acknowledged.
REQ-029 Start strobes are mutually exclusive; never more than one transfer is outstanding.

Reset
REQ-030 On rst: state IDLE; idx, counter and payload register 0; spi_start_tx, spi_start_rx, rx_valid, pl_ready, busy, cfg_done and error 0; spi_data_in and rx_data 0x00.
REQ-031 rst asserted mid-transfer aborts immediately; no further strobe is issued and outputs take their reset values asynchronously.

Structure
REQ-032 Shared package nrf_pkg holds the state encoding, opcodes W_REGISTER (0x20), W_TX_PAYLOAD (0xA0), R_RX_PAYLOAD (0x61), and the configuration byte table.
REQ-033 Sub-module nrf_cfg_rom: combinational index-to-byte lookup of CFG_LEN entries; default table 0x20,0x0E,0x21,0x00,0x23,0x03.

Verification
REQ-034 go, each done returned 3 cycles after its strobe -> 6 spi_start_tx then 6 spi_start_rx carrying bytes 0x20,0x0E,0x21,0x00,0x23,0x03; cfg_done=1.
REQ-035 In READY, pl_data=0x5A handshake; spi_data_out=0xC3 at done_rx -> tx bytes 0xA0 then 0x5A, rx byte 0x61, rx_data=0xC3 with a single rx_valid pulse.
REQ-036 Withhold spi_done_tx after the first strobe -> error=1 after 1023 cycles; a later go restarts at CFG_TX with error=0.
REQ-037 spi_done_rx injected while in WAIT_CFG_TX, and a done in the strobe cycle -> no state advance, idx unchanged.
REQ-038 rst pulsed in WAIT_PL -> all outputs 0 in that cycle; pl_valid afterwards is not acknowledged until go completes configuration.
REQ-039 go pulsed during CFG_RX and pl_valid held during configuration -> both ignored; sequence completes normally.
